// File: rtl/rx_ts_queue_ctrl.sv
// ============================================================================
// rx_ts_queue_ctrl : latches rx SFD timestamps, commits PTP frames to a FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx_ts_queue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          rx_clk,
  input  logic          rx_rst_n,
  input  logic          rx_clk_en_i,
  input  logic          rxts_trig_i,
  input  logic [79:0]   sfd_timestamp_i,
  input  logic [15:0]   sfd_timestamp_frac_ns,
  input  logic          rxts_valid_i,
  input  logic          rxts_drop_i,
  input  logic [15:0]   rx_seqId_i,
  input  logic [3:0]    rx_messageType_i,
  input  logic          int_en_i,
  input  logic          rd_pop_i,
  output logic [95:0]   ts_o,
  output logic [15:0]   seqid_o,
  output logic [3:0]    msgtype_o,
  output logic          ts_valid_o,
  output logic [AW:0]   level_o,
  output logic [7:0]    ovf_cnt_o,
  output logic          int_rx_ptp_o
);

  localparam int            EW       = 116;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [7:0]    TMO_MAX  = 8'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t           state_q;
  logic [95:0]      hold_q;
  logic [7:0]       tmo_q;
  logic [7:0]       tmo_inc;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic [7:0]       ovf_q;
  logic             int_q;

  logic             push_req;
  logic             pop_ok;
  logic             full;
  logic             push_ok;
  logic             ovf_hit;
  logic [EW-1:0]    head;

  assign tmo_inc  = tmo_q + 8'd1;
  assign push_req = rx_clk_en_i && (state_q == ST_ARMED) && rxts_valid_i;
  assign pop_ok   = rd_pop_i && (level_q != '0);
  assign full     = (level_q == FULL_LVL);
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_ok  = push_req && (!full || pop_ok);
  assign ovf_hit  = push_req && full && !pop_ok;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      tmo_q   <= '0;
    end else if (rx_clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (rxts_trig_i) begin
            hold_q  <= {sfd_timestamp_i, sfd_timestamp_frac_ns};
            tmo_q   <= '0;
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (rxts_valid_i) begin
            if (rxts_trig_i) begin
              hold_q <= {sfd_timestamp_i, sfd_timestamp_frac_ns};
              tmo_q  <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (rxts_drop_i) begin
            state_q <= ST_IDLE;
          end else if (rxts_trig_i) begin
            hold_q <= {sfd_timestamp_i, sfd_timestamp_frac_ns};
            tmo_q  <= '0;
          end else begin
            tmo_q <= tmo_inc;
            if (tmo_inc == TMO_MAX) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {hold_q, rx_seqId_i, rx_messageType_i};
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      int_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (ovf_hit && (ovf_q != 8'hFF)) begin
        ovf_q <= ovf_q + 8'd1;
      end
      level_q <= level_d;
      int_q   <= int_en_i && (level_d != '0);
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign ts_valid_o   = (level_q != '0);
  assign ts_o         = ts_valid_o ? head[EW-1:20] : '0;
  assign seqid_o      = ts_valid_o ? head[19:4]    : '0;
  assign msgtype_o    = ts_valid_o ? head[3:0]     : '0;
  assign level_o      = level_q;
  assign ovf_cnt_o    = ovf_q;
  assign int_rx_ptp_o = int_q;

endmodule

`default_nettype wire

// File: doc/rx_ts_queue_ctrl.md
# rx_ts_queue_ctrl

Receive-timestamp queue controller for the PTPv2 timestamp unit. It latches the SFD timestamp on each receive trigger and holds it while the frame parser decides whether the frame is PTP. Accepted frames are committed, together with their sequenceId and messageType, into a DEPTH-entry FIFO that software drains with a pop strobe. The block also generates the rx PTP interrupt and counts entries lost to overflow. It sits between the rx frame parser / rx timestamp plane and the register bank.

## Interface
Parameters:
- DEPTH, 4, number of queue entries (power of two, 2..16)
- AW, 2, log2(DEPTH)
- TIMEOUT, 255, maximum clock-enabled cycles in ARMED before the latched timestamp is discarded (1..255)

Ports:
- rx_clk  in  1  receive clock; the only clock
- rx_rst_n  in  1  asynchronous, active-low reset
- rx_clk_en_i  in  1  qualifies all capture-side inputs and the FSM (gmii/mii adaptation)
- rxts_trig_i  in  1  single-cycle SFD-detected pulse
- sfd_timestamp_i  in  80  {48b seconds, 32b ns}, valid in the rxts_trig_i cycle
- sfd_timestamp_frac_ns  in  16  fractional ns, valid in the rxts_trig_i cycle
- rxts_valid_i  in  1  pulse: current frame parsed as PTP, fields valid
- rxts_drop_i  in  1  pulse: current frame ended without a PTP match
- rx_seqId_i  in  16  parsed sequenceId, valid with rxts_valid_i
- rx_messageType_i  in  4  parsed messageType, valid with rxts_valid_i
- int_en_i  in  1  interrupt enable from tsu_cfg
- rd_pop_i  in  1  software pop strobe, not qualified by rx_clk_en_i
- ts_o  out  96  head entry {sec, ns, frac_ns}
- seqid_o  out  16  head entry sequenceId
- msgtype_o  out  4  head entry messageType
- ts_valid_o  out  1  queue non-empty
- level_o  out  AW+1  number of occupied entries
- ovf_cnt_o  out  8  saturating count of lost entries
- int_rx_ptp_o  out  1  level interrupt

## Operation
- FSM states: IDLE and ARMED. State and the 96-bit holding register update only when rx_clk_en_i=1.
- IDLE, rxts_trig_i=1: latch {sfd_timestamp_i, sfd_timestamp_frac_ns}, clear the timeout counter, go to ARMED.
- ARMED, rxts_valid_i=1: push {holding, rx_seqId_i, rx_messageType_i}, go to IDLE.
- ARMED, rxts_drop_i=1: go to IDLE with no push.
- ARMED, rxts_trig_i=1 with no valid/drop in the same cycle: re-latch, restart the timeout, stay in ARMED. The previous frame is silently dropped.
- Same-cycle priority in ARMED: valid > drop > trig. If valid and trig coincide, push the old entry, latch the new timestamp, and stay in ARMED.
- Timeout: counter increments on each enabled ARMED cycle. When it reaches TIMEOUT, go to IDLE with no push.
- rxts_valid_i or rxts_drop_i while in IDLE: ignored.
- FIFO: circular buffer with AW-bit read and write pointers that wrap modulo DEPTH. level runs 0..DEPTH.
- Push when full, with no pop in the same cycle: entry discarded; ovf_cnt increments, saturating at 255.
- Push and pop in the same cycle when full: both take effect and level is unchanged.
- Pop when empty: ignored.
- Head outputs (ts_o, seqid_o, msgtype_o) show the entry at the read pointer. They are 0 when empty.
- int_rx_ptp_o is registered: int_en_i & (next level != 0).

## Timing
- Reset values: all outputs 0, state IDLE, pointers 0, holding register 0. Reset mid-frame discards the ARMED entry and all queued entries immediately.
- rxts_valid_i at edge N sets ts_valid_o, level_o and int_rx_ptp_o at edge N+1.
- rd_pop_i at edge N: head advances and level decrements at edge N+1. int_rx_ptp_o falls at N+1 if the queue becomes empty.
- ovf_cnt_o updates at the edge following the rejected push.
- The timeout fires on the TIMEOUT-th enabled ARMED cycle. With rx_clk_en_i low, the timeout does not advance.
- int_en_i deassertion clears int_rx_ptp_o at the next edge without affecting the queue.

## Test plan
- Capture: trig with ts={48'h1, 32'd500}, frac=16'h8000, then valid with seqId=16'h0042, type=4'h0 → next edge: ts_valid_o=1, level_o=1, ts_o={48'h1,32'd500,16'h8000}, seqid_o=16'h0042; int_rx_ptp_o=1 when int_en_i=1.
- Drop and timeout: trig then drop → level_o stays 0. Trig with no follow-up for TIMEOUT enabled cycles, then valid → level_o stays 0.
- Overflow: 5 captured frames with DEPTH=4 and no pops → level_o=4, ovf_cnt_o=1, head seqId is the first frame's. 300 further overflows → ovf_cnt_o=255.
- Full push+pop: queue full with seqIds 1..4, push seqId 5 together with pop → level_o=4, head=2, ovf_cnt_o unchanged.
- Wrap and empty pop: 10 push/pop pairs → seqIds return in order across pointer wrap. Pop on empty → level_o=0, no underflow.
- Clock enable and reset: rx_clk_en_i at 1-in-10 with trig/valid held across enabled cycles → exactly one entry. Assert rx_rst_n low while ARMED with 2 queued → all outputs 0 at once.
